note_sequencer: RTL and testbench



---
 rtl/synth_pkg.sv | 28 ++
 rtl/seq_pattern_mem.sv | 36 +++
 rtl/note_sequencer.sv | 162 ++++++++++++++++
 tb/tb_note_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the note sequencer: FSM states and the
// note-code to oscillator-divider lookup.
package synth_pkg;

  localparam int unsigned CLK_HZ = 10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NOTE,
    ST_GAP
  } seq_state_e;

  localparam logic [15:0] DIV_REST = 16'd1;

  // Code 0 and codes 14-15 are rests; 1..13 run C4..C5 chromatically.
  localparam logic [15:0] DIV_TABLE [16] = '{
    16'd1,
    16'd38222, 16'd36078, 16'd34053, 16'd32141, 16'd30337, 16'd28634,
    16'd27027, 16'd25510, 16'd24079, 16'd22727, 16'd21452, 16'd20248,
    16'd19111,
    16'd1, 16'd1
  };

  function automatic logic note_is_rest(input logic [3:0] note);
    return (note == 4'd0) || (note >= 4'd14);
  endfunction

endpackage

// File: rtl/seq_pattern_mem.sv
// STEPS x 4-bit pattern register file: one synchronous write port, one
// asynchronous read port, cleared to rests by reset.
module seq_pattern_mem #(
  parameter int STEPS = 8,
  parameter int AW    = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data
);

  logic [3:0] mem_q [STEPS];
  logic [3:0] mem_d [STEPS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // NOTE: this array is reset on purpose: a reset must silence every slot,
  // so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < STEPS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer driving the oscillator: plays the stored pattern at a
// programmable step length, with a silent gap closing every step.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int STEPS      = 8,
  parameter int TEMPO_W    = 24,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic [TEMPO_W-1:0]       tempo,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [3:0]               wr_note,
  output logic [15:0]              divider,
  output logic                     en,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     step_pulse,
  output logic                     playing
);

  localparam int AW = $clog2(STEPS);
  localparam logic [TEMPO_W-1:0] GAP_W    = TEMPO_W'(GAP_CYCLES);
  localparam logic [TEMPO_W-1:0] GAP_LAST = TEMPO_W'(GAP_CYCLES - 1);
  localparam logic [AW-1:0]      STEP_LAST = AW'(STEPS - 1);

  seq_state_e         state_q, state_d;
  logic [AW-1:0]      step_q, step_d;
  logic [TEMPO_W-1:0] cnt_q, cnt_d;
  logic [TEMPO_W-1:0] note_last_q, note_last_d;
  logic [15:0]        divider_q, divider_d;
  logic               en_q, en_d;
  logic               pulse_q, pulse_d;
  logic               playing_q, playing_d;

  logic               enter_note;
  logic               go_idle;
  logic [AW-1:0]      next_step;
  logic [3:0]         rd_note;
  logic [TEMPO_W-1:0] tempo_eff;

  seq_pattern_mem #(.STEPS(STEPS), .AW(AW)) u_mem (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_note),
    .rd_addr (next_step),
    .rd_data (rd_note)
  );

  // Clamp so the NOTE phase always lasts at least one cycle.
  assign tempo_eff = (tempo > GAP_W) ? tempo : GAP_W + TEMPO_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    note_last_d = note_last_q;
    divider_d   = divider_q;
    en_d        = en_q;
    pulse_d     = 1'b0;
    playing_d   = playing_q;
    enter_note  = 1'b0;
    go_idle     = 1'b0;
    next_step   = step_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          enter_note  = 1'b1;
          next_step   = '0;
          note_last_d = tempo_eff - GAP_W - TEMPO_W'(1);
        end
      end
      ST_NOTE: begin
        if (cnt_q == note_last_q) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + TEMPO_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (step_q != STEP_LAST) begin
            enter_note = 1'b1;
            next_step  = step_q + AW'(1);
          end else if (loop) begin
            enter_note = 1'b1;
            next_step  = '0;
          end else begin
            go_idle = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + TEMPO_W'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    // The pattern slot is sampled only here, so later writes to the
    // sounding step cannot change it mid-step.
    if (enter_note) begin
      state_d   = ST_NOTE;
      step_d    = next_step;
      cnt_d     = '0;
      divider_d = DIV_TABLE[rd_note];
      en_d      = !note_is_rest(rd_note);
      pulse_d   = 1'b1;
      playing_d = 1'b1;
    end

    if (stop || go_idle) begin
      state_d   = ST_IDLE;
      step_d    = '0;
      cnt_d     = '0;
      divider_d = DIV_REST;
      en_d      = 1'b0;
      pulse_d   = 1'b0;
      playing_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      note_last_q <= '0;
      divider_q   <= DIV_REST;
      en_q        <= 1'b0;
      pulse_q     <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      note_last_q <= note_last_d;
      divider_q   <= divider_d;
      en_q        <= en_d;
      pulse_q     <= pulse_d;
      playing_q   <= playing_d;
    end
  end

  assign divider    = divider_q;
  assign en         = en_q;
  assign step       = step_q;
  assign step_pulse = pulse_q;
  assign playing    = playing_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with GAP_CYCLES=2: per-cycle tables for
// basic play and tempo clamp, hand sequences for loop, stop and reset.
`timescale 1ns/1ps
module tb_note_sequencer;

  localparam int STEPS   = 8;
  localparam int TEMPO_W = 24;
  localparam int GAP     = 2;
  localparam int AW      = 3;

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop = 1'b0;
  logic [TEMPO_W-1:0] tempo = '0;
  logic               wr_en = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic [3:0]         wr_note = '0;
  logic [15:0]        divider;
  logic               en;
  logic [AW-1:0]      step;
  logic               step_pulse;
  logic               playing;

  note_sequencer #(.STEPS(STEPS), .TEMPO_W(TEMPO_W), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .tempo      (tempo),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_note    (wr_note),
    .divider    (divider),
    .en         (en),
    .step       (step),
    .step_pulse (step_pulse),
    .playing    (playing)
  );

  always #50 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  note;
    logic [15:0] exp_div;
  } step_vec_t;

  typedef struct {
    int  exp_step;
    bit  exp_pulse;
    bit  exp_en;
    int  exp_div;
    bit  do_write;
    int  waddr;
    int  wnote;
  } cyc_vec_t;

  step_vec_t basic [8];
  cyc_vec_t  clamp [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int s, input bit p,
                            input bit e, input int d, input bit pl);
    check({tag, ".step"},    32'(step),       32'(s));
    check({tag, ".pulse"},   32'(step_pulse), 32'(p));
    check({tag, ".en"},      32'(en),         32'(e));
    check({tag, ".divider"}, 32'(divider),    32'(d));
    check({tag, ".playing"}, 32'(playing),    32'(pl));
  endtask

  task automatic write_slot(input int a, input int n);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_note = 4'(n);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input int t, input bit lp);
    tempo = TEMPO_W'(t);
    loop  = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    basic[0] = '{4'd10, 16'd22727};
    basic[1] = '{4'd1,  16'd38222};
    basic[2] = '{4'd0,  16'd1};
    basic[3] = '{4'd13, 16'd19111};
    for (int i = 4; i < 8; i++) basic[i] = '{4'd0, 16'd1};

    // tempo=1 clamps to 3: 1 NOTE cycle then 2 GAP cycles per step.
    // Slot 2 is rewritten to code 5 while step 1 plays.
    clamp[0] = '{0, 1'b1, 1'b1, 22727, 1'b0, 0, 0};
    clamp[1] = '{0, 1'b0, 1'b0, 22727, 1'b0, 0, 0};
    clamp[2] = '{0, 1'b0, 1'b0, 22727, 1'b0, 0, 0};
    clamp[3] = '{1, 1'b1, 1'b1, 38222, 1'b1, 2, 5};
    clamp[4] = '{1, 1'b0, 1'b0, 38222, 1'b0, 0, 0};
    clamp[5] = '{1, 1'b0, 1'b0, 38222, 1'b0, 0, 0};
    clamp[6] = '{2, 1'b1, 1'b1, 30337, 1'b0, 0, 0};
    clamp[7] = '{2, 1'b0, 1'b0, 30337, 1'b0, 0, 0};
    clamp[8] = '{2, 1'b0, 1'b0, 30337, 1'b0, 0, 0};
    clamp[9] = '{3, 1'b1, 1'b1, 19111, 1'b0, 0, 0};

    // Reset state
    #130;
    check_outs("reset", 0, 1'b0, 1'b0, 1, 1'b0);
    #40 nrst = 1'b1;
    tick();
    check_outs("post_reset", 0, 1'b0, 1'b0, 1, 1'b0);

    for (int i = 0; i < STEPS; i++) write_slot(i, int'(basic[i].note));

    // Basic play, no loop
    do_start(10, 1'b0);
    for (int i = 0; i < 80; i++) begin
      automatic int s = i / 10;
      automatic int c = i % 10;
      automatic bit e = (c < 8) && (basic[s].exp_div != 16'd1);
      check_outs($sformatf("basic[%0d]", i), s, c == 0, e, int'(basic[s].exp_div), 1'b1);
      tick();
    end
    check_outs("basic_end", 0, 1'b0, 1'b0, 1, 1'b0);

    // Loop: wraps to step 0 after 80 cycles
    do_start(10, 1'b1);
    repeat (79) tick();
    check_outs("loop_last", 7, 1'b0, 1'b0, 1, 1'b1);
    tick();
    check_outs("loop_wrap", 0, 1'b1, 1'b1, 22727, 1'b1);
    do_stop();
    check_outs("loop_stop", 0, 1'b0, 1'b0, 1, 1'b0);
    loop = 1'b0;

    // Stop sampled in cycle 3 of step 1
    do_start(10, 1'b0);
    repeat (12) tick();
    check_outs("stop_pre", 1, 1'b0, 1'b1, 38222, 1'b1);
    do_stop();
    check_outs("stop_post", 0, 1'b0, 1'b0, 1, 1'b0);

    // Simultaneous start and stop in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_outs("start_stop", 0, 1'b0, 1'b0, 1, 1'b0);

    // Write to the currently sounding slot does not change the note
    do_start(10, 1'b0);
    tick();
    write_slot(0, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cur_write[%0d].divider", i), 32'(divider), 32'd22727);
      check($sformatf("cur_write[%0d].en", i), 32'(en), 32'd1);
      tick();
    end
    do_stop();
    write_slot(0, 10);

    // Tempo clamp and live write to a future slot
    do_start(1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check_outs($sformatf("clamp[%0d]", i), clamp[i].exp_step, clamp[i].exp_pulse,
                 clamp[i].exp_en, clamp[i].exp_div, 1'b1);
      if (clamp[i].do_write) begin
        wr_en   = 1'b1;
        wr_addr = AW'(clamp[i].waddr);
        wr_note = 4'(clamp[i].wnote);
      end
      tick();
      wr_en = 1'b0;
    end
    do_stop();

    // Asynchronous reset mid-play, then every slot must be a rest
    do_start(10, 1'b1);
    repeat (5) tick();
    check("pre_reset.en", 32'(en), 32'd1);
    #20 nrst = 1'b0;
    #5;
    check_outs("async_reset", 0, 1'b0, 1'b0, 1, 1'b0);
    #20 nrst = 1'b1;
    tick();
    do_start(3, 1'b0);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("cleared[%0d].divider", i), 32'(divider), 32'd1);
      check($sformatf("cleared[%0d].en", i), 32'(en), 32'd0);
      check($sformatf("cleared[%0d].step", i), 32'(step), 32'(i / 3));
      tick();
    end
    check("cleared_end.playing", 32'(playing), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
